// File: rtl/chu_mmio_arb_pkg.sv
// chu_mmio_arb_pkg
//   Shared types and constants for the two-master FPro MMIO arbiter.
//   - arb_state_t : arbiter FSM states (IDLE -> ISSUE -> ACK -> IDLE)
//   - mst_idx_t   : index of a bus master (one bit for two masters)
//   - NUM_MASTERS : number of masters sharing the bus
package chu_mmio_arb_pkg;

   localparam int NUM_MASTERS = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ACK   = 2'd2
   } arb_state_t;

   typedef logic mst_idx_t;

endpackage

// File: rtl/chu_rr_arb2.sv
// chu_rr_arb2
//   Combinational two-way round-robin pick with lock support.
//   Ports:
//     req        in   per-master request
//     last       in   master served most recently (loses a tie)
//     lock_en    in   bus is locked to lock_owner
//     lock_owner in   master holding the lock
//     valid      out  some eligible master is requesting
//     gnt        out  index of the chosen master (meaningful when valid)
module chu_rr_arb2
   import chu_mmio_arb_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] req,
   input  mst_idx_t               last,
   input  logic                   lock_en,
   input  mst_idx_t               lock_owner,
   output logic                   valid,
   output mst_idx_t               gnt
);

   logic [NUM_MASTERS-1:0] eligible;

   // While locked, only the owner's request is visible to the pick.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_elig
         assign eligible[gi] = req[gi] & (~lock_en | (lock_owner == mst_idx_t'(gi)));
      end
   endgenerate

   assign valid = |eligible;

   // Master 1 wins when it is the only one asking, or on a tie when
   // master 0 was the last one served.
   assign gnt = eligible[1] & (~eligible[0] | ~last);

endmodule

// File: rtl/chu_mmio_arbiter.sv
// chu_mmio_arbiter
//   Shares the single-cycle FPro MMIO bus between two request/ack masters.
//   Round-robin between masters, with an optional lock that keeps the bus
//   with one master across transactions (atomic read-modify-write).
//   Every transaction takes IDLE (grant) -> ISSUE (bus strobe) -> ACK.
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     m_req/m_wr/m_lock per-master request, direction (1=write), lock
//     m_addr/m_wr_data  per-master address and write data
//     m_ack             one-cycle completion pulse to the served master
//     m_rd_data         read data, valid in the m_ack cycle, held on writes
//     mmio_*            FPro bus side (cs/wr/rd strobes, addr, data)
//   All outputs come straight from registers.
module chu_mmio_arbiter
   import chu_mmio_arb_pkg::*;
#(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 32
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_MASTERS-1:0]              m_req,
   input  logic [NUM_MASTERS-1:0]              m_wr,
   input  logic [NUM_MASTERS-1:0]              m_lock,
   input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr,
   input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wr_data,
   output logic [NUM_MASTERS-1:0]              m_ack,
   output logic [DATA_W-1:0]                   m_rd_data,
   output logic                                mmio_cs,
   output logic                                mmio_wr,
   output logic                                mmio_rd,
   output logic [ADDR_W-1:0]                   mmio_addr,
   output logic [DATA_W-1:0]                   mmio_wr_data,
   input  logic [DATA_W-1:0]                   mmio_rd_data
);

   arb_state_t             state_reg;
   mst_idx_t               gnt_reg;
   logic                   wr_reg;
   logic                   lock_reg;        // lock bit of the transaction in flight
   mst_idx_t               last_reg;
   logic                   lock_en_reg;
   mst_idx_t               lock_owner_reg;
   logic [ADDR_W-1:0]      addr_reg;
   logic [DATA_W-1:0]      wr_data_reg;
   logic [DATA_W-1:0]      rd_data_reg;
   logic [NUM_MASTERS-1:0] ack_reg;
   logic                   cs_reg;
   logic                   bus_wr_reg;
   logic                   bus_rd_reg;

   logic                   pick_valid;
   mst_idx_t               pick_gnt;

   chu_rr_arb2 u_pick (
      .req        (m_req),
      .last       (last_reg),
      .lock_en    (lock_en_reg),
      .lock_owner (lock_owner_reg),
      .valid      (pick_valid),
      .gnt        (pick_gnt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         gnt_reg        <= 1'b0;
         wr_reg         <= 1'b0;
         lock_reg       <= 1'b0;
         last_reg       <= 1'b1;   // master 0 wins the first tie
         lock_en_reg    <= 1'b0;
         lock_owner_reg <= 1'b0;
         addr_reg       <= '0;
         wr_data_reg    <= '0;
         rd_data_reg    <= '0;
         ack_reg        <= '0;
         cs_reg         <= 1'b0;
         bus_wr_reg     <= 1'b0;
         bus_rd_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick_valid) begin
                  gnt_reg     <= pick_gnt;
                  wr_reg      <= m_wr[pick_gnt];
                  lock_reg    <= m_lock[pick_gnt];
                  addr_reg    <= m_addr[pick_gnt];
                  wr_data_reg <= m_wr_data[pick_gnt];
                  // Strobes are set up here so they are registered
                  // outputs throughout the ISSUE cycle.
                  cs_reg      <= 1'b1;
                  bus_wr_reg  <= m_wr[pick_gnt];
                  bus_rd_reg  <= ~m_wr[pick_gnt];
                  state_reg   <= ISSUE;
               end
            end
            ISSUE: begin
               if (!wr_reg)
                  rd_data_reg <= mmio_rd_data;
               last_reg         <= gnt_reg;
               cs_reg           <= 1'b0;
               bus_wr_reg       <= 1'b0;
               bus_rd_reg       <= 1'b0;
               ack_reg          <= '0;
               ack_reg[gnt_reg] <= 1'b1;
               state_reg        <= ACK;
            end
            ACK: begin
               ack_reg        <= '0;
               // A locked transaction keeps the bus; an unlocked one frees it.
               lock_en_reg    <= lock_reg;
               lock_owner_reg <= gnt_reg;
               state_reg      <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign m_ack        = ack_reg;
   assign m_rd_data    = rd_data_reg;
   assign mmio_cs      = cs_reg;
   assign mmio_wr      = bus_wr_reg;
   assign mmio_rd      = bus_rd_reg;
   assign mmio_addr    = addr_reg;
   assign mmio_wr_data = wr_data_reg;

endmodule

// File: doc/chu_mmio_arbiter.md
# chu_mmio_arbiter

Two-master arbiter that shares the single FPro MMIO bus between the processor and a second bus master, such as a debug or DMA engine. It sits between the masters and the MMIO controller's bus port. Masters use a request/acknowledge handshake; the arbiter serialises their accesses onto the single-cycle FPro bus. It uses round-robin priority, with an optional lock so one master can do an atomic read-modify-write, e.g. on the LED or SPI slot registers.

## Interface
- ADDR_W, 21, FPro MMIO address width
- DATA_W, 32, FPro data width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m_req  in  2  per-master request; held high with fields stable until m_ack
- m_wr  in  2  per-master direction, 1 = write, 0 = read
- m_lock  in  2  per-master lock request, sampled with m_req
- m_addr  in  2×ADDR_W  per-master address
- m_wr_data  in  2×DATA_W  per-master write data
- m_ack  out  2  one-cycle completion pulse to the granted master
- m_rd_data  out  DATA_W  read data, valid in the m_ack cycle (shared by both masters)
- mmio_cs, mmio_wr, mmio_rd  out  1 each  FPro bus strobes
- mmio_addr  out  ADDR_W  FPro address
- mmio_wr_data  out  DATA_W  FPro write data
- mmio_rd_data  in  DATA_W  FPro read data, valid in the same cycle as mmio_cs

## Operation
- FSM has three states: IDLE, ISSUE and ACK.
- **IDLE**
  - If the arbiter is locked, only the owner's m_req is considered.
  - Otherwise, a single requester wins.
  - If both request, the master not served last wins (round-robin pointer `last`).
  - On a grant, register `gnt`, m_wr, m_addr, m_wr_data and m_lock of the winner, then go to ISSUE.
- **ISSUE**
  - Drive mmio_cs=1.
  - Drive mmio_wr=wr and mmio_rd=~wr.
  - Drive mmio_addr and mmio_wr_data from the registered fields.
  - On a read, capture mmio_rd_data into the m_rd_data register at the cycle's clock edge.
  - Set `last`=gnt.
  - Go to ACK.
- **ACK**
  - m_ack[gnt]=1 for exactly one cycle.
  - Lock state updates here: owner:=gnt if the registered lock=1, else the lock is cleared.
  - Go to IDLE unconditionally.
- Master rule: deassert m_req, or present a new transaction, in the cycle after m_ack. A req still high in IDLE is treated as a new request.
- While locked, the other master is starved indefinitely. This is intended; the owner must end with lock=0.
- On a write cycle, m_rd_data holds its previous value.

## Timing
- Request seen in IDLE at cycle n:
  - bus strobe at n+1
  - m_ack at n+2
  - IDLE again at n+3
- Minimum 3 cycles per transaction; maximum throughput one access per 3 cycles.
- Worst-case wait for an unlocked master is one competing transaction: grant no later than the 2nd IDLE cycle after its request.
- All outputs are registered: no combinational path from m_* to mmio_* or from mmio_rd_data to m_rd_data.
- Reset, asynchronous at any time, including mid-ISSUE or ACK:
  - state=IDLE, lock cleared, `last`=1 (master 0 wins the first tie)
  - m_ack=0, mmio_cs/wr/rd=0, mmio_addr=0, mmio_wr_data=0, m_rd_data=0
  - An in-flight access is abandoned with no ack.

## Structure
- Package chu_mmio_arb_pkg holds:
  - state enum `arb_state_t` {IDLE, ISSUE, ACK}
  - master index type (1 bit)
  - NUM_MASTERS=2 constant
- Sub-module chu_rr_arb2: combinational two-way round-robin pick.
  - Inputs: req[1:0], last, lock_en, lock_owner.
  - Outputs: valid, gnt.
- Remaining FSM, field registers and lock logic live in the top module.

## Test plan
- Single read, master 0 only: addr=0x000C0, bus returns 0xDEADBEEF.
  - Required: mmio_rd=1 one cycle after req.
  - Required: m_ack[0] one cycle later with m_rd_data=0xDEADBEEF.
- Simultaneous writes from both masters right after reset:
  - master 0 granted first, master 1 next
  - mmio_wr_data sequence is 0x11 then 0x22
  - exactly one m_ack per master
- Both masters hold req continuously for 6 transactions:
  - grants alternate 0,1,0,1,0,1
  - each access takes exactly 3 cycles
- Master 1 locked read of 0x000C0 then unlocked write of 0x000C0, while master 0 requests throughout:
  - master 0 is not granted until after master 1's write ack.
- Reset asserted during ISSUE:
  - mmio_cs drops immediately
  - no m_ack
  - after release, the pending master 0 request is granted first.
- Back-to-back read then write by master 0 with a new request in the cycle after ack:
  - second strobe occurs 3 cycles after the first
  - m_rd_data keeps the read value through the write.
